// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the five-stage MIPS core.
// Optional fetch-exception checking is enabled by defining FETCH_EXC_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_en,
  input  logic        if_id_en,
  input  logic        flush_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        exc_d
);

  logic [31:0] pc_f;
  logic [31:0] pc_next;
  logic        fetch_exc;
  logic [31:0] fetch_instr;

`ifdef FETCH_EXC_EN
  // Misaligned, below the image base, or past the end of instruction memory.
  function automatic logic fetch_fault(input logic [31:0] pc);
    logic [32:0] im_limit;
    im_limit = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);
    return (pc[1:0] != 2'b00) || (pc < IM_BASE) || ({1'b0, pc} >= im_limit);
  endfunction

  assign fetch_exc = fetch_fault(pc_f);
`else
  assign fetch_exc = 1'b0;
`endif

  assign im_addr     = pc_f;
  assign pc8_d       = pc_d + 32'd8;
  assign fetch_instr = fetch_exc ? 32'h0000_0000 : im_rdata;

  // Next-PC selection: a stall beats any redirect, which beats sequential fetch.
  always_comb begin
    pc_next = pc_f;
    if (!pc_en) begin
      pc_next = pc_f;
    end else if (redirect_valid) begin
      pc_next = redirect_target;
    end else begin
      pc_next = pc_f + 32'd4;
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f <= RESET_PC;
    end else begin
      pc_f <= pc_next;
    end
  end

  // IF/ID register; a flush inserts a bubble even while the register is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d <= 32'h0000_0000;
      pc_d    <= 32'h0000_0000;
      valid_d <= 1'b0;
      exc_d   <= 1'b0;
    end else if (flush_d) begin
      instr_d <= 32'h0000_0000;
      pc_d    <= pc_f;
      valid_d <= 1'b0;
      exc_d   <= 1'b0;
    end else if (if_id_en) begin
      instr_d <= fetch_instr;
      pc_d    <= pc_f;
      valid_d <= 1'b1;
      exc_d   <= fetch_exc;
    end else begin
      instr_d <= instr_d;
      pc_d    <= pc_d;
      valid_d <= valid_d;
      exc_d   <= exc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: free run, stall, redirect, flush,
// exception addresses and asynchronous reset mid-stall.
module tb_fetch_stage;

`ifdef FETCH_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_en, if_id_en, flush_d, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] im_addr, im_rdata, instr_d, pc_d, pc8_d;
  logic        valid_d, exc_d;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Expected latched word for an address that faults only when checking is built in.
  function automatic logic [31:0] bad_word(input logic [31:0] a);
    return EXC ? 32'h0000_0000 : mem_word(a);
  endfunction

  assign im_rdata = mem_word(im_addr);

  fetch_stage dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .if_id_en(if_id_en), .flush_d(flush_d),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .im_addr(im_addr), .im_rdata(im_rdata), .instr_d(instr_d), .pc_d(pc_d),
    .pc8_d(pc8_d), .valid_d(valid_d), .exc_d(exc_d)
  );

  typedef struct {
    logic        pc_en, if_id_en, flush_d, rv;
    logic [31:0] rt;
    logic [31:0] e_addr, e_instr, e_pc;
    logic        e_valid, e_exc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic pe, input logic ie, input logic fl, input logic rv,
                     input logic [31:0] rt, input logic [31:0] ea, input logic [31:0] ei,
                     input logic [31:0] ep, input logic ev, input logic ex);
    vec_t v;
    v.pc_en = pe; v.if_id_en = ie; v.flush_d = fl; v.rv = rv; v.rt = rt;
    v.e_addr = ea; v.e_instr = ei; v.e_pc = ep; v.e_valid = ev; v.e_exc = ex;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] ea, input logic [31:0] ei,
                           input logic [31:0] ep, input logic ev, input logic ex);
    check({tag, ".im_addr"}, im_addr, ea);
    check({tag, ".instr_d"}, instr_d, ei);
    check({tag, ".pc_d"},    pc_d, ep);
    check({tag, ".pc8_d"},   pc8_d, ep + 32'd8);
    check({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, ev});
    check({tag, ".exc_d"},   {31'd0, exc_d}, {31'd0, ex});
  endtask

  initial begin
    // Free run from reset.
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3004, mem_word(32'h3000), 32'h3000, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3008, mem_word(32'h3004), 32'h3004, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h300C, mem_word(32'h3008), 32'h3008, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3010, mem_word(32'h300C), 32'h300C, 1'b1, 1'b0);
    // Three-cycle stall at 0x3010, with a redirect that must be ignored.
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3010, mem_word(32'h300C), 32'h300C, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h5000, 32'h3010, mem_word(32'h300C), 32'h300C, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3010, mem_word(32'h300C), 32'h300C, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3014, mem_word(32'h3010), 32'h3010, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3018, mem_word(32'h3014), 32'h3014, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h301C, mem_word(32'h3018), 32'h3018, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3020, mem_word(32'h301C), 32'h301C, 1'b1, 1'b0);
    // Redirect at 0x3020: delay slot reaches decode, target goes to im_addr.
    add(1'b1, 1'b1, 1'b0, 1'b1, 32'h3100, 32'h3100, mem_word(32'h3020), 32'h3020, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3104, mem_word(32'h3100), 32'h3100, 1'b1, 1'b0);
    // Flush beats if_id_en=0; PC follows its own enable.
    add(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h3108, 32'h0, 32'h3104, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h3108, 32'h0, 32'h3108, 1'b0, 1'b0);
    // Mismatched enables.
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3108, mem_word(32'h3108), 32'h3108, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h310C, mem_word(32'h3108), 32'h3108, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'h4000, 32'h310C, mem_word(32'h310C), 32'h310C, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3110, mem_word(32'h310C), 32'h310C, 1'b1, 1'b0);
    // Misaligned target, then below-base target.
    add(1'b1, 1'b1, 1'b0, 1'b1, 32'h3102, 32'h3102, mem_word(32'h3110), 32'h3110, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3106, bad_word(32'h3102), 32'h3102, 1'b1, EXC);
    add(1'b1, 1'b1, 1'b0, 1'b1, 32'h2FFC, 32'h2FFC, bad_word(32'h3106), 32'h3106, 1'b1, EXC);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3000, bad_word(32'h2FFC), 32'h2FFC, 1'b1, EXC);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3004, mem_word(32'h3000), 32'h3000, 1'b1, 1'b0);
    // Upper bound: last legal word, then first illegal word.
    add(1'b1, 1'b1, 1'b0, 1'b1, 32'h6FFC, 32'h6FFC, mem_word(32'h3004), 32'h3004, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h7000, mem_word(32'h6FFC), 32'h6FFC, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h7004, bad_word(32'h7000), 32'h7000, 1'b1, EXC);
    // PC wrap modulo 2^32 (pc8_d also wraps).
    add(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, bad_word(32'h7004), 32'h7004, 1'b1, EXC);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0000, bad_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b1, EXC);

    reset = 1'b1;
    pc_en = 1'b1; if_id_en = 1'b1; flush_d = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    #12;
    check_all("reset", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("post_reset.im_addr", im_addr, 32'h3000);

    for (int i = 0; i < vecs.size(); i++) begin
      pc_en = vecs[i].pc_en; if_id_en = vecs[i].if_id_en; flush_d = vecs[i].flush_d;
      redirect_valid = vecs[i].rv; redirect_target = vecs[i].rt;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_pc,
                vecs[i].e_valid, vecs[i].e_exc);
    end

    // Asynchronous reset mid-stall, with a pending redirect.
    pc_en = 1'b1; if_id_en = 1'b1; flush_d = 1'b0; redirect_valid = 1'b0;
    @(posedge clk); #1;
    pc_en = 1'b0; if_id_en = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h3200;
    @(posedge clk); #2;
    check("stall.valid_d", {31'd0, valid_d}, 32'd1);
    reset = 1'b1;
    #1;
    check_all("async_reset", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);
    pc_en = 1'b1; if_id_en = 1'b1;
    @(posedge clk); #1;
    check_all("reset_held", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);
    #3;
    reset = 1'b0; redirect_valid = 1'b0;
    @(posedge clk); #1;
    check_all("restart", 32'h3004, mem_word(32'h3000), 32'h3000, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage plus IF/ID pipeline register for the five-stage MIPS core. Holds the PC, drives the instruction-memory address, and latches fetched instruction, PC and PC+8 into the decode stage. Sits directly upstream of decode and the hazard unit:
- consumes the hazard unit's PC-write enable and IF/ID enable;
- consumes the decode stage's branch/jump redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- IM_BASE, 32'h0000_3000, lowest legal instruction address
- IM_WORDS, 4096, number of 32-bit words in instruction memory

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- pc_en  input  1  PC write enable (low = stall PC)
- if_id_en  input  1  IF/ID register load enable (low = hold decode contents)
- flush_d  input  1  clear IF/ID to a bubble on next edge
- redirect_valid  input  1  decode stage resolved a taken branch/jump this cycle
- redirect_target  input  32  next PC when redirect_valid=1
- im_addr  output  32  instruction memory byte address (= current PC)
- im_rdata  input  32  instruction word, combinational read of im_addr
- instr_d  output  32  instruction in decode
- pc_d  output  32  PC of instr_d
- pc8_d  output  32  pc_d + 8 (jal link value)
- valid_d  output  1  instr_d is a real instruction, not a bubble
- exc_d  output  1  fetch exception flag for instr_d (only with FETCH_EXC_EN)

## Operation
- Architectural state is limited to:
  - PC register pc_f;
  - IF/ID register {instr_d, pc_d, valid_d, exc_d}.
- pc8_d is combinational from pc_d.
- im_addr = pc_f at all times (combinational).
- Next PC, evaluated at each rising edge, in this priority order:
  - pc_en=0: pc_f holds, and redirect_valid is ignored. Decode only asserts redirect when not stalled.
  - redirect_valid=1: pc_f <= redirect_target.
  - otherwise: pc_f <= pc_f + 4. The sum wraps modulo 2^32 with no overflow detection.
- Delayed branches:
  - the instruction fetched in the cycle of a redirect is the delay slot;
  - it is latched into IF/ID normally and is never squashed by redirect.
- IF/ID update at each rising edge, in this priority order:
  - flush_d=1: instr_d<=0, pc_d<=pc_f, valid_d<=0, exc_d<=0. flush_d wins over if_id_en=0.
  - if_id_en=0: all IF/ID fields hold.
  - otherwise: instr_d<=im_rdata (or 0 on exception), pc_d<=pc_f, valid_d<=1, exc_d<=fetch exception.
- pc_en and if_id_en are normally driven identically by the hazard unit. Mismatched values are legal, and each register obeys only its own enable.
- A bubble (instr_d=0) is sll $0,$0,0, so downstream stages treat it as a no-op.

## Timing
- Reset values, effective immediately on reset assertion without waiting for a clock edge:
  - pc_f=RESET_PC, so im_addr=RESET_PC;
  - instr_d=0, pc_d=0, pc8_d=8, valid_d=0, exc_d=0.
- First cycle after reset deassertion: im_addr=RESET_PC. At the first edge, instr_d takes mem[RESET_PC] and valid_d=1.
- Latency: an instruction appears on instr_d one edge after its address is on im_addr.
- Stall of N cycles: im_addr and all IF/ID outputs are frozen for exactly N edges. Fetch then resumes with no lost or duplicated instruction.
- Redirect: target appears on im_addr the cycle after redirect_valid. The delay slot is in decode that same cycle.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values at once, and pending enables are discarded.

## Configuration
- FETCH_EXC_EN defined: a fetch exception is raised when pc_f[1:0]!=0, pc_f<IM_BASE, or pc_f>=IM_BASE+4*IM_WORDS.
  - On exception, the latched instr_d is 0 and exc_d=1.
  - pc_d still records the faulting PC.
  - The PC sequence is unchanged; handling belongs to later stages.
- FETCH_EXC_EN undefined:
  - exc_d is tied to 0 and no range/alignment logic is generated;
  - im_rdata is always latched.

## Test plan
- Reset then free-run, im_rdata=addr-derived pattern: im_addr steps 0x3000, 0x3004, 0x3008. instr_d lags by one edge, valid_d=1 from the first edge, pc8_d=pc_d+8.
- Assert pc_en=if_id_en=0 for 3 cycles at PC 0x3010: im_addr stays 0x3010 and instr_d/pc_d stay frozen for 3 edges. Next edge loads the 0x3010 instruction, with no skip or duplicate.
- Pulse redirect_valid with target 0x3100 while PC=0x3020: decode receives the 0x3020 delay slot, then im_addr=0x3100, then 0x3104.
- flush_d=1 together with if_id_en=0: next edge gives instr_d=0, valid_d=0. PC follows pc_en independently.
- Assert reset asynchronously mid-cycle during a stall: im_addr=0x3000, instr_d=0, valid_d=0 immediately, before any clock edge.
- With FETCH_EXC_EN, redirect to 0x3102 and separately to 0x2FFC: next IF/ID has exc_d=1, instr_d=0, pc_d equal to the bad address. Without the macro, exc_d=0 and instr_d=im_rdata.
